// File: rtl/ex_muldiv_if.sv
// Request/response bundle between ID/EX, the RV32M multiply/divide unit and EX/MEM.
// The master side issues ops and gates the clock; the slave side is the unit.
interface ex_muldiv_if #(
  parameter int XLEN     = 32,
  parameter int REG_ADDR = 5
);
  logic                clk_en;
  logic                i_flush;
  logic                i_valid;
  logic                o_ready;
  logic [2:0]          i_funct3;
  logic [XLEN-1:0]     i_rs1;
  logic [XLEN-1:0]     i_rs2;
  logic [REG_ADDR-1:0] i_rd;
  logic                o_valid;
  logic [XLEN-1:0]     o_result;
  logic [REG_ADDR-1:0] o_rd;
  logic                o_busy;

  modport master (
    output clk_en, i_flush, i_valid, i_funct3, i_rs1, i_rs2, i_rd,
    input  o_ready, o_valid, o_result, o_rd, o_busy
  );

  modport slave (
    input  clk_en, i_flush, i_valid, i_funct3, i_rs1, i_rs2, i_rd,
    output o_ready, o_valid, o_result, o_rd, o_busy
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: shift-add (or single '*') multiply and
// restoring divide on operand magnitudes, sign fixed up when entering DONE.
module ex_muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int REG_ADDR = 5,
  parameter int FAST_MUL = 1
) (
  input  logic     clk,
  input  logic     rst,
  ex_muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg;
  logic [2*XLEN-1:0]   acc_reg;
  logic [XLEN-1:0]     opb_reg;
  logic [1:0]          funct3_reg;
  logic                neg_reg;
  logic [REG_ADDR-1:0] rd_lat_reg;
  logic [XLEN-1:0]     result_reg;
  logic [REG_ADDR-1:0] rd_reg;

  // Operand decode for the op being offered this cycle
  logic            is_div, a_signed, b_signed, neg_a, neg_b, div_zero, div_ovf, special, accept;
  logic [XLEN-1:0] mag_a, mag_b, special_result;

  assign is_div   = bus.i_funct3[2];
  assign a_signed = is_div ? !bus.i_funct3[0] : (bus.i_funct3[1:0] != 2'b11);
  assign b_signed = is_div ? !bus.i_funct3[0] : !bus.i_funct3[1];
  assign neg_a    = a_signed && bus.i_rs1[XLEN-1];
  assign neg_b    = b_signed && bus.i_rs2[XLEN-1];
  assign mag_a    = neg_a ? -bus.i_rs1 : bus.i_rs1;
  assign mag_b    = neg_b ? -bus.i_rs2 : bus.i_rs2;
  assign div_zero = is_div && (bus.i_rs2 == '0);
  assign div_ovf  = is_div && !bus.i_funct3[0] && (bus.i_rs2 == '1)
                    && (bus.i_rs1 == {1'b1, {(XLEN-1){1'b0}}});
  assign special  = div_zero || div_ovf;
  assign special_result = div_zero ? (bus.i_funct3[1] ? bus.i_rs1 : '1)
                                   : (bus.i_funct3[1] ? '0 : bus.i_rs1);
  assign accept   = bus.i_valid && (state_reg == IDLE) && !bus.i_flush;

  // One iteration step; acc_reg holds {high/remainder, low/quotient}
  logic [XLEN:0]     mul_sum, rem_shift, diff;
  logic [2*XLEN-1:0] mul_step, fast_prod, div_step, acc_iter, mul_full;
  logic [XLEN-1:0]   div_val, div_res, iter_result;
  logic              last;

  assign mul_sum   = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
  assign mul_step  = {mul_sum, acc_reg[XLEN-1:1]};
  assign fast_prod = (2*XLEN)'(acc_reg[XLEN-1:0]) * (2*XLEN)'(opb_reg);
  assign rem_shift = acc_reg[2*XLEN-1:XLEN-1];
  assign diff      = rem_shift - {1'b0, opb_reg};
  assign div_step  = diff[XLEN] ? {rem_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0}
                                : {diff[XLEN-1:0],      acc_reg[XLEN-2:0], 1'b1};
  assign acc_iter  = (state_reg == DIV) ? div_step : ((FAST_MUL != 0) ? fast_prod : mul_step);

  assign mul_full    = neg_reg ? -acc_iter : acc_iter;
  assign div_val     = funct3_reg[1] ? acc_iter[2*XLEN-1:XLEN] : acc_iter[XLEN-1:0];
  assign div_res     = neg_reg ? -div_val : div_val;
  assign iter_result = (state_reg == DIV) ? div_res
                     : ((funct3_reg == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN]);
  assign last        = (cnt_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else if (bus.clk_en) begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (bus.i_valid) state_next = !is_div ? MUL : (special ? DONE : DIV);
      MUL, DIV: if (last) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (bus.i_flush) state_next = IDLE;
  end

  always_comb begin
    bus.o_ready = (state_reg == IDLE);
    bus.o_busy  = (state_reg != IDLE);
    bus.o_valid = (state_reg == DONE) && !bus.i_flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opb_reg    <= '0;
      funct3_reg <= '0;
      neg_reg    <= 1'b0;
      rd_lat_reg <= '0;
      result_reg <= '0;
      rd_reg     <= '0;
    end else if (bus.clk_en) begin
      if (accept) begin
        funct3_reg <= bus.i_funct3[1:0];
        rd_lat_reg <= bus.i_rd;
        acc_reg    <= {{XLEN{1'b0}}, mag_a};
        opb_reg    <= mag_b;
        // Remainder follows the dividend; everything else follows the product sign
        neg_reg    <= (is_div && bus.i_funct3[1]) ? neg_a : (neg_a ^ neg_b);
        cnt_reg    <= (!is_div && FAST_MUL != 0) ? '0 : CW'(XLEN-1);
        if (special) begin
          result_reg <= special_result;
          rd_reg     <= bus.i_rd;
        end
      end else if ((state_reg == MUL || state_reg == DIV) && !bus.i_flush) begin
        acc_reg <= acc_iter;
        if (last) begin
          result_reg <= iter_result;
          rd_reg     <= rd_lat_reg;
        end else begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end
    end
  end

  assign bus.o_result = result_reg;
  assign bus.o_rd     = rd_reg;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: a FAST_MUL=1 and a FAST_MUL=0 instance share
// clock, reset and operand buses; results, latency and handshake are checked per op.
module tb_ex_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        clk_en = 1'b1, flush = 1'b0, valid_f = 1'b0, valid_s = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [4:0]  rd = '0;
  bit          sel_slow = 1'b0;

  ex_muldiv_if #(.XLEN(32), .REG_ADDR(5)) f_if ();
  ex_muldiv_if #(.XLEN(32), .REG_ADDR(5)) s_if ();

  assign f_if.clk_en = clk_en;   assign s_if.clk_en = clk_en;
  assign f_if.i_flush = flush;   assign s_if.i_flush = flush;
  assign f_if.i_valid = valid_f; assign s_if.i_valid = valid_s;
  assign f_if.i_funct3 = funct3; assign s_if.i_funct3 = funct3;
  assign f_if.i_rs1 = rs1;       assign s_if.i_rs1 = rs1;
  assign f_if.i_rs2 = rs2;       assign s_if.i_rs2 = rs2;
  assign f_if.i_rd = rd;         assign s_if.i_rd = rd;

  ex_muldiv_unit #(.XLEN(32), .REG_ADDR(5), .FAST_MUL(1)) dut_fast (.clk(clk), .rst(rst), .bus(f_if));
  ex_muldiv_unit #(.XLEN(32), .REG_ADDR(5), .FAST_MUL(0)) dut_slow (.clk(clk), .rst(rst), .bus(s_if));

  logic        mon_valid, mon_ready, mon_busy;
  logic [31:0] mon_result;
  logic [4:0]  mon_rd;
  assign mon_valid  = sel_slow ? s_if.o_valid  : f_if.o_valid;
  assign mon_ready  = sel_slow ? s_if.o_ready  : f_if.o_ready;
  assign mon_busy   = sel_slow ? s_if.o_busy   : f_if.o_busy;
  assign mon_result = sel_slow ? s_if.o_result : f_if.o_result;
  assign mon_rd     = sel_slow ? s_if.o_rd     : f_if.o_rd;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_op(input bit slow, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] d, input string tag);
    int w;
    sel_slow = slow;
    w = 0;
    while (!mon_ready && w < 100) begin step(); w++; end
    chk({tag, " ready"}, 32'(mon_ready), 32'd1);
    funct3 = f3; rs1 = a; rs2 = b; rd = d;
    if (slow) valid_s = 1'b1; else valid_f = 1'b1;
    step();
    valid_f = 1'b0; valid_s = 1'b0;
  endtask

  // Accepts at edge T, then watches cycles ending at T+1 .. T+lat+3
  task automatic run_op(input bit slow, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d, input logic [31:0] exp,
                        input int lat, input string tag);
    int first, vcnt, bcnt;
    logic [31:0] res;
    logic [4:0]  rdo;
    accept_op(slow, f3, a, b, d, tag);
    first = 0; vcnt = 0; bcnt = 0; res = '0; rdo = '0;
    for (int kk = 1; kk <= lat + 3; kk++) begin
      if (mon_valid) begin
        vcnt++;
        if (first == 0) begin first = kk; res = mon_result; rdo = mon_rd; end
      end
      if (kk <= lat && mon_busy && !mon_ready) bcnt++;
      step();
    end
    chk({tag, " latency"}, 32'(first), 32'(lat));
    chk({tag, " result"}, res, exp);
    chk({tag, " rd"}, 32'(rdo), 32'(d));
    chk({tag, " valid_cycles"}, 32'(vcnt), 32'd1);
    chk({tag, " busy_cycles"}, 32'(bcnt), 32'(lat));
    $display("op %-14s a=%08h b=%08h result=%08h expected=%08h latency=%0d", tag, a, b, res, exp, first);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int vcnt, first;
    logic [31:0] res;

    repeat (3) step();
    chk("reset busy",   32'(f_if.o_busy),   32'd0);
    chk("reset ready",  32'(f_if.o_ready),  32'd1);
    chk("reset valid",  32'(f_if.o_valid),  32'd0);
    chk("reset result", f_if.o_result,      32'd0);
    chk("reset rd",     32'(f_if.o_rd),     32'd0);
    chk("reset slow busy", 32'(s_if.o_busy), 32'd0);
    rst = 1'b0;
    step();

    run_op(0, 3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 2,  "f MUL");
    run_op(0, 3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 2,  "f MULH");
    run_op(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 2,  "f MULHU");
    run_op(0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 2,  "f MULHSU");

    run_op(1, 3'b000, 32'd7,        32'hFFFFFFFD, 5'd9,  32'hFFFFFFEB, 33, "s MUL");
    run_op(1, 3'b001, 32'h80000000, 32'h80000000, 5'd10, 32'h40000000, 33, "s MULH");
    run_op(1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'hFFFFFFFE, 33, "s MULHU");
    run_op(1, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'hFFFFFFFF, 33, "s MULHSU");

    run_op(0, 3'b100, 32'hFFFFFFF9, 32'd2,        5'd13, 32'hFFFFFFFD, 33, "DIV");
    run_op(0, 3'b110, 32'hFFFFFFF9, 32'd2,        5'd14, 32'hFFFFFFFF, 33, "REM");
    run_op(0, 3'b101, 32'd100,      32'd7,        5'd15, 32'd14,       33, "DIVU");
    run_op(0, 3'b111, 32'd100,      32'd7,        5'd16, 32'd2,        33, "REMU");

    run_op(0, 3'b101, 32'd5,        32'd0,        5'd17, 32'hFFFFFFFF, 1,  "DIVU by0");
    run_op(0, 3'b110, 32'd5,        32'd0,        5'd18, 32'd5,        1,  "REM by0");
    run_op(0, 3'b100, 32'd5,        32'd0,        5'd19, 32'hFFFFFFFF, 1,  "DIV by0");
    run_op(0, 3'b111, 32'd5,        32'd0,        5'd20, 32'd5,        1,  "REMU by0");
    run_op(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h80000000, 1,  "DIV ovf");
    run_op(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd22, 32'd0,        1,  "REM ovf");

    // Flush a DIV at T+10; a MUL accepted at T+11 must complete normally
    accept_op(0, 3'b100, 32'd100, 32'd7, 5'd23, "flush DIV");
    vcnt = 0;
    for (int kk = 1; kk <= 9; kk++) begin
      if (mon_valid) vcnt++;
      step();
    end
    flush = 1'b1;
    if (mon_valid) vcnt++;
    step();
    flush = 1'b0;
    chk("flush no valid", 32'(vcnt), 32'd0);
    chk("flush ready",    32'(mon_ready), 32'd1);
    $display("op flush DIV     valid_seen=%0d ready_after=%0b", vcnt, mon_ready);
    run_op(0, 3'b000, 32'd3, 32'd4, 5'd24, 32'd12, 2, "MUL post-flush");

    // Asynchronous reset in the middle of a DIV
    accept_op(0, 3'b100, 32'hFFFFFFF9, 32'd2, 5'd25, "rst DIV");
    for (int kk = 1; kk <= 4; kk++) step();
    #1 rst = 1'b1;
    #1;
    chk("rst busy",   32'(mon_busy),  32'd0);
    chk("rst valid",  32'(mon_valid), 32'd0);
    chk("rst result", mon_result,     32'd0);
    chk("rst rd",     32'(mon_rd),    32'd0);
    $display("op rst mid-DIV   busy=%0b valid=%0b result=%08h", mon_busy, mon_valid, mon_result);
    #1 rst = 1'b0;
    step();

    // clk_en low for five edges mid-DIV stretches latency by five
    accept_op(0, 3'b101, 32'd100, 32'd7, 5'd26, "hold DIVU");
    vcnt = 0; first = 0; res = '0;
    for (int kk = 1; kk <= 41; kk++) begin
      clk_en = !(kk >= 10 && kk <= 14);
      if (mon_valid) begin
        vcnt++;
        if (first == 0) begin first = kk; res = mon_result; end
      end
      step();
    end
    clk_en = 1'b1;
    chk("hold latency",      32'(first), 32'd38);
    chk("hold result",       res,        32'd14);
    chk("hold valid_cycles", 32'(vcnt),  32'd1);
    $display("op hold DIVU     result=%08h latency=%0d", res, first);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
